switch_step_conditioner: RTL and testbench

- Front-end conditioner for the lab FSMs driven from board switches.
- Takes the raw 2-bit state-select switches and the raw "manual clock" step switch.
- Synchronises and debounces them, then presents clean `sw_out` to the downstream state machine's `in` input.
- Issues a single-cycle `step_pulse` that the downstream FSM uses as its state-advance enable, in place of a raw switch used as a clock.

---
 rtl/switch_step_conditioner.sv | 88 ++++++++
 tb/tb_switch_step_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_step_conditioner.sv
// Switch front-end for the lab FSMs. Each switch, and the step switch, passes through a
// two-flop synchroniser and a counting debouncer. Clean switch levels appear on sw_out.
// A debounced press of the step switch gives a single-cycle advance enable.
module switch_step_conditioner #(
  parameter int unsigned W               = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_in,
  input  logic         step_sw,
  output logic [W-1:0] sw_out,
  output logic         step_pulse,
  output logic         sw_change,
  output logic         stable
);

  // Channels 0..W-1 are the select switches; channel W is the step switch.
  localparam int unsigned NCh = W + 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NCh-1:0]   raw;
  logic [NCh-1:0]   sync1_q, sync2_q;
  logic [NCh-1:0]   deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [NCh];
  logic [CNT_W-1:0] cnt_d [NCh];
  logic             step_pulse_q, step_pulse_d;
  logic             sw_change_q, sw_change_d;

  assign raw = {step_sw, sw_in};

  // Debounce next state: a level is accepted once it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    for (int i = 0; i < NCh; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
    step_pulse_d = deb_d[W] & ~deb_q[W];
    sw_change_d  = |(deb_d[W-1:0] ^ deb_q[W-1:0]);
  end

  // Synchronisers, debounce state and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      step_pulse_q <= 1'b0;
      sw_change_q  <= 1'b0;
      for (int i = 0; i < NCh; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      step_pulse_q <= step_pulse_d;
      sw_change_q  <= sw_change_d;
      for (int i = 0; i < NCh; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Idle when no channel is mid-qualification.
  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < NCh; i++) begin
      if ((sync2_q[i] != deb_q[i]) || (cnt_q[i] != '0)) begin
        stable = 1'b0;
      end
    end
  end

  assign sw_out     = deb_q[W-1:0];
  assign step_pulse = step_pulse_q;
  assign sw_change  = sw_change_q;

endmodule

// File: tb/tb_switch_step_conditioner.sv
// Bench for switch_step_conditioner: directed scenarios plus random switch activity, all
// checked every cycle against a sample-history reference model.
module tb_switch_step_conditioner;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int NCH = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_in;
  logic         step_sw;
  logic [W-1:0] sw_out;
  logic         step_pulse;
  logic         sw_change;
  logic         stable;

  int tests = 0;
  int fails = 0;

  // Reference model: raw pipeline, debounced value, and the last N synchronised samples.
  bit m_r1    [NCH];
  bit m_r2    [NCH];
  bit m_d     [NCH];
  bit m_sprev [NCH];
  bit hist    [NCH][$];
  bit m_pulse;
  bit m_change;

  switch_step_conditioner #(
    .W              (W),
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_in     (sw_in),
    .step_sw   (step_sw),
    .sw_out    (sw_out),
    .step_pulse(step_pulse),
    .sw_change (sw_change),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model using the levels present at the edge, then check.
  task automatic tick();
    bit [NCH-1:0] raw;
    bit           d_old [NCH];
    bit           s_pre;
    bit           all_diff;
    bit           exp_stable;
    @(posedge clk);
    raw = {step_sw, sw_in};
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_r1[c] = 0; m_r2[c] = 0; m_d[c] = 0; m_sprev[c] = 0;
        hist[c].delete();
      end
      m_pulse  = 0;
      m_change = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        d_old[c] = m_d[c];
        s_pre    = m_r2[c];
        hist[c].push_back(s_pre);
        if (hist[c].size() > N) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == N);
        foreach (hist[c][k]) if (hist[c][k] == m_d[c]) all_diff = 0;
        if (all_diff) m_d[c] = s_pre;
        m_sprev[c] = s_pre;
        m_r2[c]    = m_r1[c];
        m_r1[c]    = raw[c];
      end
      m_pulse  = m_d[W] && !d_old[W];
      m_change = (m_d[0] != d_old[0]) || (m_d[1] != d_old[1]);
    end
    #1;
    exp_stable = 1;
    for (int c = 0; c < NCH; c++) begin
      if (m_r2[c] != m_d[c] || m_sprev[c] != m_d[c]) exp_stable = 0;
    end
    check("sw_out", 32'(sw_out), 32'({m_d[1], m_d[0]}));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("sw_change", 32'(sw_change), 32'(m_change));
    check("stable", 32'(stable), 32'(exp_stable));
  endtask

  initial begin
    int cnt;
    int first;

    // Reset held with every switch high.
    reset = 1; sw_in = 2'b11; step_sw = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sw_out", 32'(sw_out), 32'd0);
      check("rst_stable", 32'(stable), 32'd1);
    end

    // Step held high through reset release: one pulse after 2+N edges.
    reset = 0; sw_in = 2'b00;
    cnt = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step_sw && step_pulse === 1'b1) begin cnt++; if (first == 0) first = i; end
    end
    check("rel_pulse_cnt", 32'(cnt), 32'd1);
    check("rel_pulse_at", 32'(first), 32'd6);
    step_sw = 0;
    repeat (10) tick();

    // Clean change 00 -> 10.
    sw_in = 2'b10;
    cnt = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (sw_change === 1'b1) begin cnt++; if (first == 0) first = i; end
      if (i == 1 || i == 6) check("clean_stable", 32'(stable), (i == 1) ? 32'd1 : 32'd1);
      if (i >= 2 && i <= 5) check("clean_busy", 32'(stable), 32'd0);
    end
    check("clean_chg_cnt", 32'(cnt), 32'd1);
    check("clean_chg_at", 32'(first), 32'd6);
    check("clean_value", 32'(sw_out), 32'h2);
    sw_in = 2'b00;
    repeat (10) tick();

    // Glitch on bit0 shorter than N.
    sw_in = 2'b01;
    repeat (3) tick();
    sw_in = 2'b00;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sw_change === 1'b1) cnt++;
    end
    check("glitch_chg", 32'(cnt), 32'd0);
    check("glitch_value", 32'(sw_out), 32'd0);
    check("glitch_settled", 32'(stable), 32'd1);

    // Step press held 20 cycles, then release.
    step_sw = 1;
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse === 1'b1) begin cnt++; if (first == 0) first = i; end
    end
    check("press_cnt", 32'(cnt), 32'd1);
    check("press_at", 32'(first), 32'd6);
    step_sw = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step_pulse === 1'b1) cnt++;
    end
    check("release_cnt", 32'(cnt), 32'd0);

    // Bouncing press: 1,1,0,0,... for 10 cycles, then held high.
    cnt = 0; first = 0;
    for (int i = 1; i <= 25; i++) begin
      step_sw = (i > 10) ? 1'b1 : ((((i - 1) / 2) % 2) == 0);
      tick();
      if (step_pulse === 1'b1) begin cnt++; if (first == 0) first = i; end
    end
    check("bounce_cnt", 32'(cnt), 32'd1);
    check("bounce_at", 32'(first), 32'd14);
    step_sw = 0;
    repeat (10) tick();

    // Reset in the middle of qualifying sw_in=01.
    sw_in = 2'b01;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (first == 0 && sw_out === 2'b01) first = i;
    end
    check("midrst_at", 32'(first), 32'd6);
    check("midrst_value", 32'(sw_out), 32'h1);

    // Random activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) sw_in = W'($urandom);
      if ($urandom_range(0, 5) == 0) step_sw = ~step_sw;
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
